bit_serial_adder: RTL
=====================

BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rstN  input  1  reset; synchronous and active-low.
REQ-004 start  input  1  request to begin an addition; sampled on the rising edge.
REQ-005 a  input  WIDTH  operand A; sampled only on the edge where start is accepted.
REQ-006 b  input  WIDTH  operand B; sampled only on the edge where start is accepted.
REQ-007 cIn  input  1  carry-in; sampled only on the edge where start is accepted.
REQ-008 busy  output  1  high while the addition is in progress (state ADD).
REQ-009 done  output  1  one-cycle pulse marking that sum and cOut hold a new result.
REQ-010 sum  output  WIDTH  registered result, a+b+cIn modulo 2^WIDTH.
REQ-011 cOut  output  1  registered carry-out of the WIDTH-bit addition.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, ADD, DONE.
REQ-013 In IDLE or DONE, start=1 SHALL be accepted: load a, b and cIn into internal shift and carry registers, clear the bit counter, and go to ADD.
REQ-014 In IDLE with start=0, the FSM SHALL remain in IDLE; in DONE with start=0, it SHALL go to IDLE.
REQ-015 In ADD, start SHALL be ignored, and operand inputs SHALL have no effect.
REQ-016 Each ADD cycle SHALL process one bit, LSB first, with a single 1-bit full adder: s = aLsb^bLsb^carry, c = majority(aLsb, bLsb, carry).
REQ-017 Each ADD cycle SHALL update the carry register with c, shift both operand registers right by one, shift s into the MSB of the partial-sum register, and increment the bit counter.
REQ-018 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide, and the FSM SHALL leave ADD after exactly WIDTH ADD cycles (counter reaches WIDTH-1 and is processed).
REQ-019 On the ADD->DONE transition, sum SHALL load the completed partial sum and cOut SHALL load the final carry.
REQ-020 sum and cOut SHALL NOT change at any other time except reset, including during ADD.
REQ-021 Latency: if start is accepted at edge E0, ADD SHALL occupy cycles E0..E(WIDTH), and done=1 with a valid result SHALL be visible from edge E(WIDTH) to edge E(WIDTH+1).
REQ-022 done SHALL be 1 only in DONE, and busy SHALL be 1 only in ADD; the two SHALL never be high together.
REQ-023 Back-to-back operation: start=1 in the DONE cycle SHALL begin a new addition with no idle cycle, so done pulses are spaced exactly WIDTH+1 cycles apart.
REQ-024 Arithmetic SHALL be unsigned with wrap-around, and overflow SHALL be signalled only through cOut.

Reset
REQ-025 On an edge with rstN=0, the FSM SHALL enter IDLE and clear the shift, carry and counter registers, regardless of state or start.
REQ-026 Reset values SHALL be busy=0, done=0, sum=0, cOut=0.
REQ-027 Reset in ADD SHALL abort the operation, and no done pulse SHALL follow for the aborted operation.
REQ-028 If rstN=0 and start=1 on the same edge, reset SHALL win and the start SHALL be discarded.
REQ-029 With rstN=1 and start=1 on the first edge after reset release, the start SHALL be accepted normally.

Verification (WIDTH=8)
REQ-030 a=0x5A, b=0x3C, cIn=0, start pulsed -> busy high for 8 cycles, then done one cycle with sum=0x96, cOut=0.
REQ-031 a=0xFF, b=0x01, cIn=0 -> sum=0x00, cOut=1; and a=0xFF, b=0xFF, cIn=1 -> sum=0xFF, cOut=1.
REQ-032 a=0x00, b=0x00, cIn=1 -> sum=0x01, cOut=0; sum and cOut SHALL hold that value until the next done.
REQ-033 Start 0x10+0x20, then pulse start with a=0xAA, b=0x55 at cycle 3 of ADD -> second request ignored, result 0x30, cOut=0.
REQ-034 Hold start=1 continuously with 0x01+0x01, then 0x02+0x02 -> done pulses 9 cycles apart with sum=0x02 then 0x04.
REQ-035 Start 0xF0+0x0F, then rstN=0 at ADD cycle 4 -> next edge busy=0, done=0, sum=0x00, cOut=0; no done pulse appears within the following 10 cycles.

Source files
------------

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB first through a single
// full adder, one bit per clock, and reports the result with a one-cycle done pulse.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cOut
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] psum_next;

    always_comb begin
        fa_s      = a_sh[0] ^ b_sh[0] ^ carry;
        fa_c      = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        psum_next = {fa_s, psum[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cOut  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        psum  <= '0;
                        carry <= cIn;
                        cnt   <= '0;
                        state <= ADD;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ADD: begin
                    carry <= fa_c;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    psum  <= psum_next;
                    cnt   <= cnt + 1'b1;
                    // Last bit: publish the result in the same edge that enters DONE.
                    if (cnt == LAST) begin
                        sum   <= psum_next;
                        cOut  <= fa_c;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
